sam_mouse_if: RTL and testbench



---
 rtl/sam_mouse_if_pkg.sv | 46 ++++
 rtl/sam_mouse_if_if.sv | 18 +
 rtl/sam_mouse_pkt.sv | 113 +++++++++++
 rtl/sam_mouse_if.sv | 116 +++++++++++
 tb/tb_sam_mouse_if.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/sam_mouse_if_pkg.sv
// ==========================================================================
// sam_mouse_if_pkg : shared constants, types and helpers for the SAM mouse
// interface.                                                    Rev 1.0
// ==========================================================================
`default_nettype none

package sam_mouse_if_pkg;

  localparam int ACC_W = 12;

  localparam logic [3:0] IDX_HDR0  = 4'd0;
  localparam logic [3:0] IDX_BTN   = 4'd1;
  localparam logic [3:0] IDX_Y_HI  = 4'd2;
  localparam logic [3:0] IDX_Y_MID = 4'd3;
  localparam logic [3:0] IDX_Y_LO  = 4'd4;
  localparam logic [3:0] IDX_X_HI  = 4'd5;
  localparam logic [3:0] IDX_X_MID = 4'd6;
  localparam logic [3:0] IDX_X_LO  = 4'd7;
  localparam logic [3:0] IDX_TRAIL = 4'd8;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } pkt_state_t;

  // 64-bit product: GAP_TIMEOUT_US * CLK_HZ overflows a 32-bit int.
  function automatic int timeout_cycles(input int clk_hz, input int us);
    longint prod;
    prod = longint'(clk_hz) * longint'(us);
    return int'(prod / longint'(1000000));
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [8:0]       d);
    logic [ACC_W:0] sum;
    sum = {acc[ACC_W-1], acc} + {{(ACC_W-8){d[8]}}, d};
    if (sum[ACC_W] != sum[ACC_W-1])
      sat_add = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_add = sum[ACC_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sam_mouse_if_if.sv
// ==========================================================================
// sam_mouse_if_if : PS/2 byte input, CPU read select and mouse nibble output
// bundle.                                                       Rev 1.0
// ==========================================================================
`default_nettype none

interface sam_mouse_if_if;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;
  logic       rdmsel;
  logic [3:0] mdata;
  logic       pkt_err;

  modport master (output ps2_byte, ps2_byte_valid, rdmsel, input mdata, pkt_err);
  modport slave  (input ps2_byte, ps2_byte_valid, rdmsel, output mdata, pkt_err);
endinterface

`default_nettype wire

// File: rtl/sam_mouse_pkt.sv
// ==========================================================================
// sam_mouse_pkt : PS/2 3-byte packet assembler with inter-byte gap timeout.
//                                                               Rev 1.0
// ==========================================================================
`default_nettype none

module sam_mouse_pkt
  import sam_mouse_if_pkg::*;
#(
  parameter int CLK_HZ         = 12000000,
  parameter int GAP_TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       commit,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [2:0] buttons,
  output logic       pkt_err
);

  localparam int GAP_CYC = timeout_cycles(CLK_HZ, GAP_TIMEOUT_US);
  localparam int GAP_W   = $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  pkt_state_t       state, state_nxt;
  logic             ld_b0, ld_b1, ld_b2, err_nxt, gap_expired;
  logic             ovf_x, ovf_y, sgn_x, sgn_y;
  logic [2:0]       btn;
  logic [7:0]       b1, b2;
  logic [GAP_W-1:0] gap_cnt;

  assign gap_expired = (gap_cnt == GAP_LAST);

  always_comb begin
    state_nxt = state;
    ld_b0     = 1'b0;
    ld_b1     = 1'b0;
    ld_b2     = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      WAIT_B0: begin
        if (byte_valid) begin
          if (byte_in[3]) begin
            ld_b0     = 1'b1;
            state_nxt = WAIT_B1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      WAIT_B1: begin
        if (byte_valid) begin
          ld_b1     = 1'b1;
          state_nxt = WAIT_B2;
        end else if (gap_expired) begin
          state_nxt = WAIT_B0;
        end
      end
      WAIT_B2: begin
        if (byte_valid) begin
          ld_b2     = 1'b1;
          state_nxt = WAIT_B0;
        end else if (gap_expired) begin
          state_nxt = WAIT_B0;
        end
      end
      default: state_nxt = WAIT_B0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_B0;
      gap_cnt <= '0;
      ovf_y   <= 1'b0;
      ovf_x   <= 1'b0;
      sgn_y   <= 1'b0;
      sgn_x   <= 1'b0;
      btn     <= 3'b000;
      b1      <= 8'h00;
      b2      <= 8'h00;
      commit  <= 1'b0;
      pkt_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      commit  <= ld_b2;
      pkt_err <= err_nxt;
      if (byte_valid || state == WAIT_B0 || gap_expired)
        gap_cnt <= '0;
      else
        gap_cnt <= gap_cnt + 1'b1;
      if (ld_b0) begin
        ovf_y <= byte_in[7];
        ovf_x <= byte_in[6];
        sgn_y <= byte_in[5];
        sgn_x <= byte_in[4];
        btn   <= byte_in[2:0];
      end
      if (ld_b1) b1 <= byte_in;
      if (ld_b2) b2 <= byte_in;
    end
  end

  assign dx      = ovf_x ? 9'd0 : {sgn_x, b1};
  assign dy      = ovf_y ? 9'd0 : {sgn_y, b2};
  assign buttons = btn;

endmodule

`default_nettype wire

// File: rtl/sam_mouse_if.sv
// ==========================================================================
// sam_mouse_if : PS/2 mouse packets to SAM Coupe nibble-sequenced mouse port.
//                                                               Rev 1.0
// ==========================================================================
`default_nettype none

module sam_mouse_if
  import sam_mouse_if_pkg::*;
#(
  parameter int CLK_HZ          = 12000000,
  parameter int READ_TIMEOUT_US = 50,
  parameter int GAP_TIMEOUT_US  = 2000
) (
  input  logic          clk,
  input  logic          rst_n,
  sam_mouse_if_if.slave bus
);

  localparam int READ_CYC = timeout_cycles(CLK_HZ, READ_TIMEOUT_US);
  localparam int RD_W     = $clog2(READ_CYC + 1);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(READ_CYC - 1);
  localparam logic [RD_W-1:0] RD_DONE = RD_W'(READ_CYC);

  logic             commit, pkt_err_w;
  logic [8:0]       dx, dy;
  logic [2:0]       pkt_buttons, buttons;
  logic             rd_q, rd_rise, rd_fall, rd_timeout, snap;
  logic [3:0]       idx, mdata_r, mdata_nxt;
  logic [RD_W-1:0]  rd_cnt;
  logic [ACC_W-1:0] acc_x, acc_y, acc_x_nxt, acc_y_nxt, sx, sy;

  sam_mouse_pkt #(
    .CLK_HZ         (CLK_HZ),
    .GAP_TIMEOUT_US (GAP_TIMEOUT_US)
  ) u_pkt (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (bus.ps2_byte),
    .byte_valid (bus.ps2_byte_valid),
    .commit     (commit),
    .dx         (dx),
    .dy         (dy),
    .buttons    (pkt_buttons),
    .pkt_err    (pkt_err_w)
  );

  assign rd_rise    = bus.rdmsel & ~rd_q;
  assign rd_fall    = ~bus.rdmsel & rd_q;
  assign rd_timeout = ~(rd_rise | rd_fall) & (rd_cnt == RD_LAST);
  assign snap       = rd_rise & (idx == IDX_BTN);

  // A commit landing on the snapshot edge seeds the freshly cleared accumulator.
  always_comb begin
    acc_x_nxt = acc_x;
    acc_y_nxt = acc_y;
    if (snap) begin
      acc_x_nxt = commit ? sat_add('0, dx) : '0;
      acc_y_nxt = commit ? sat_add('0, dy) : '0;
    end else if (commit) begin
      acc_x_nxt = sat_add(acc_x, dx);
      acc_y_nxt = sat_add(acc_y, dy);
    end
  end

  always_comb begin
    mdata_nxt = 4'hF;
    case (idx)
      IDX_BTN:   mdata_nxt = {1'b1, ~buttons};
      IDX_Y_HI:  mdata_nxt = sy[11:8];
      IDX_Y_MID: mdata_nxt = sy[7:4];
      IDX_Y_LO:  mdata_nxt = sy[3:0];
      IDX_X_HI:  mdata_nxt = sx[11:8];
      IDX_X_MID: mdata_nxt = sx[7:4];
      IDX_X_LO:  mdata_nxt = sx[3:0];
      default:   mdata_nxt = 4'hF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 1'b0;
      idx     <= IDX_HDR0;
      rd_cnt  <= '0;
      acc_x   <= '0;
      acc_y   <= '0;
      sx      <= '0;
      sy      <= '0;
      buttons <= 3'b000;
      mdata_r <= 4'hF;
    end else begin
      rd_q    <= bus.rdmsel;
      acc_x   <= acc_x_nxt;
      acc_y   <= acc_y_nxt;
      mdata_r <= mdata_nxt;
      if (snap) begin
        sx <= acc_x;
        sy <= acc_y;
      end
      if (commit) buttons <= pkt_buttons;
      if (rd_rise || rd_fall)
        rd_cnt <= '0;
      else if (rd_cnt != RD_DONE)
        rd_cnt <= rd_cnt + 1'b1;
      if (rd_timeout)
        idx <= IDX_HDR0;
      else if (rd_fall)
        idx <= (idx == IDX_TRAIL) ? IDX_HDR0 : idx + 4'd1;
    end
  end

  assign bus.mdata   = mdata_r;
  assign bus.pkt_err = pkt_err_w;

endmodule

`default_nettype wire

// File: tb/tb_sam_mouse_if.sv
// ==========================================================================
// tb_sam_mouse_if : directed self-checking bench for sam_mouse_if.
//                                                               Rev 1.0
// ==========================================================================
`default_nettype none

module tb_sam_mouse_if;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic e;
  logic [3:0] n;

  sam_mouse_if_if bus ();

  sam_mouse_if dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic err);
    bus.ps2_byte       = b;
    bus.ps2_byte_valid = 1'b1;
    tick(1);
    err = bus.pkt_err;
    bus.ps2_byte_valid = 1'b0;
    tick(2);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic err;
    send_byte(b0, err);
    send_byte(b1, err);
    send_byte(b2, err);
  endtask

  task automatic rd_nib(output logic [3:0] nib);
    bus.rdmsel = 1'b1;
    tick(3);
    nib = bus.mdata;
    bus.rdmsel = 1'b0;
    tick(3);
  endtask

  // exp is left-aligned: first nibble read lives in exp[35:32].
  task automatic rd_run(input string tag, input logic [35:0] exp, input int cnt);
    logic [3:0] nib;
    logic [3:0] want;
    for (int i = 0; i < cnt; i++) begin
      rd_nib(nib);
      want = exp[35-4*i -: 4];
      chk($sformatf("%s[%0d]", tag, i), {28'd0, nib}, {28'd0, want});
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.ps2_byte       = 8'h00;
    bus.ps2_byte_valid = 1'b0;
    bus.rdmsel         = 1'b0;
    tick(3);
    chk("rst_mdata", {28'd0, bus.mdata}, 32'hF);
    chk("rst_pkt_err", {31'd0, bus.pkt_err}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // idle sequence, then index wraps back to header
    rd_run("t1", 36'hFF000000F, 9);
    rd_run("t1_wrap", 36'hFF0000000, 2);

    // left button, dx=+5, dy=+3; second sequence has no motion
    send_pkt(8'h09, 8'h05, 8'h03);
    tick(700);
    rd_run("t2a", 36'hFE003005F, 9);
    rd_run("t2b", 36'hFE000000F, 9);

    // dx=-2 (FFE), dy=-128 (F80)
    send_pkt(8'h38, 8'hFE, 8'h80);
    tick(700);
    rd_run("t3", 36'hFFF80FFEF, 9);

    // positive saturation, then overflow bits suppress the deltas
    repeat (20) send_pkt(8'h08, 8'hFF, 8'h00);
    tick(700);
    rd_run("t4a", 36'hFF0007FFF, 9);
    repeat (20) send_pkt(8'hC8, 8'hFF, 8'hFF);
    tick(700);
    rd_run("t4b", 36'hFF000000F, 9);

    // sync failure and gap timeout
    send_byte(8'h00, e);
    chk("t5_err_pulse", {31'd0, e}, 32'd1);
    chk("t5_err_clear", {31'd0, bus.pkt_err}, 32'd0);
    send_byte(8'h08, e);
    chk("t5_b0_ok", {31'd0, e}, 32'd0);
    send_byte(8'h01, e);
    tick(24100);
    send_byte(8'h08, e);
    chk("t5_gap_noerr", {31'd0, e}, 32'd0);
    send_byte(8'h02, e);
    send_byte(8'h00, e);
    tick(700);
    rd_run("t5", 36'hFF000002F, 9);

    // read timeout restarts the sequence at the header
    send_pkt(8'h0A, 8'h00, 8'h00);
    tick(700);
    rd_run("t6_pre", 36'hFD0000000, 3);
    tick(610);
    rd_run("t6_restart", 36'hFD0000000, 2);

    // commit coincides with the index-1 snapshot edge
    tick(700);
    send_pkt(8'h08, 8'h03, 8'h00);
    rd_run("t6_hdr", 36'hF00000000, 1);
    send_byte(8'h08, e);
    send_byte(8'h07, e);
    bus.ps2_byte       = 8'h00;
    bus.ps2_byte_valid = 1'b1;
    tick(1);
    bus.ps2_byte_valid = 1'b0;
    bus.rdmsel         = 1'b1;
    tick(3);
    n = bus.mdata;
    chk("t6_coinc_btn", {28'd0, n}, 32'hF);
    bus.rdmsel = 1'b0;
    tick(3);
    rd_run("t6_old", 36'h000003F00, 7);
    rd_run("t6_new", 36'hFF000007F, 9);

    // reset mid-packet discards partial packet and accumulated motion
    send_pkt(8'h08, 8'h09, 8'h00);
    send_byte(8'h08, e);
    rd_run("t7_pre", 36'hF00000000, 1);
    rst_n = 1'b0;
    tick(2);
    chk("t7_rst_mdata", {28'd0, bus.mdata}, 32'hF);
    rst_n = 1'b1;
    tick(2);
    send_byte(8'h05, e);
    chk("t7_fsm_b0", {31'd0, e}, 32'd1);
    tick(700);
    rd_run("t7", 36'hFF000000F, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
